// File: rtl/game_round_ctrl.sv
// -----------------------------------------------------------------------------
// game_round_ctrl
//
// Round sequencer for the torpedo game. It places a new target, launches the
// torpedo when the player presses the key, and judges each flight as a hit or
// a miss. It keeps the score and miss counts and starts the end-of-game timer
// when a round ends the game (a hit, or the final miss).
//
// Ports
//   clk                        in   rising-edge clock for all logic
//   reset                      in   synchronous reset, active low
//   key                        in   launch button (asynchronous level)
//   target_within_screen       in   target sprite is on screen
//   torpedo_within_screen      in   torpedo sprite is on screen
//   collision                  in   overlap detector output
//   end_of_game_timer_running  in   end-of-game timer busy
//   sprite_target_write        out  1-cycle pulse: load target position/velocity
//   sprite_torpedo_write       out  1-cycle pulse: launch torpedo
//   end_of_game_timer_start    out  1-cycle pulse: start end-of-game timer
//   game_won                   out  level, set after a hit until the timer ends
//   game_over                  out  level, set after the final miss until the timer ends
//   score                      out  hits this game (saturating)
//   misses                     out  misses this game
//   state                      out  current FSM state (debug)
// -----------------------------------------------------------------------------
module game_round_ctrl #(
  parameter int SCORE_WIDTH   = 4,
  parameter int MISS_WIDTH    = 2,
  parameter int MAX_MISSES    = 3,
  parameter int TIMEOUT_WIDTH = 25
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   key,
  input  logic                   target_within_screen,
  input  logic                   torpedo_within_screen,
  input  logic                   collision,
  input  logic                   end_of_game_timer_running,
  output logic                   sprite_target_write,
  output logic                   sprite_torpedo_write,
  output logic                   end_of_game_timer_start,
  output logic                   game_won,
  output logic                   game_over,
  output logic [SCORE_WIDTH-1:0] score,
  output logic [MISS_WIDTH-1:0]  misses,
  output logic [2:0]             state
);

  typedef enum logic [2:0] {
    ST_START         = 3'd0,
    ST_AIM           = 3'd1,
    ST_FLIGHT        = 3'd2,
    ST_END_WAIT_RISE = 3'd3,
    ST_END_WAIT_FALL = 3'd4
  } state_t;

  localparam logic [SCORE_WIDTH-1:0]   SCORE_MAX    = {SCORE_WIDTH{1'b1}};
  localparam logic [MISS_WIDTH-1:0]    MISS_LIMIT   = MISS_WIDTH'(MAX_MISSES);
  // The counter is compared one step early so that the miss registers on the
  // same edge at which the counter would reach all-ones.
  localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_PRE  = {TIMEOUT_WIDTH{1'b1}} - 1'b1;
  localparam logic [1:0]               WATCHDOG_END = 2'd3;

  state_t                   state_q, state_d;
  logic                     key_sync1_q, key_sync1_d;
  logic                     key_sync2_q, key_sync2_d;
  logic                     key_sync3_q, key_sync3_d;
  logic                     key_rise_q, key_rise_d;
  logic                     target_armed_q, target_armed_d;
  logic                     torpedo_armed_q, torpedo_armed_d;
  logic [TIMEOUT_WIDTH-1:0] timeout_cnt_q, timeout_cnt_d;
  logic [1:0]               watchdog_q, watchdog_d;
  logic                     target_write_q, target_write_d;
  logic                     torpedo_write_q, torpedo_write_d;
  logic                     timer_start_q, timer_start_d;
  logic                     game_won_q, game_won_d;
  logic                     game_over_q, game_over_d;
  logic [SCORE_WIDTH-1:0]   score_q, score_d;
  logic [MISS_WIDTH-1:0]    misses_q, misses_d;

  logic                     target_exit;
  logic                     torpedo_exit;
  logic                     timeout_hit;
  logic [MISS_WIDTH-1:0]    misses_inc;

  // An exit only counts once the sprite has actually been seen on screen;
  // within_screen flags update per frame and may be stale right after a write.
  assign target_exit  = target_armed_q & ~target_within_screen;
  assign torpedo_exit = torpedo_armed_q & ~torpedo_within_screen;
  assign timeout_hit  = (timeout_cnt_q == TIMEOUT_PRE);
  assign misses_inc   = misses_q + 1'b1;

  always_comb begin
    state_d         = state_q;
    target_armed_d  = target_armed_q;
    torpedo_armed_d = torpedo_armed_q;
    timeout_cnt_d   = timeout_cnt_q;
    watchdog_d      = watchdog_q;
    target_write_d  = 1'b0;
    torpedo_write_d = 1'b0;
    timer_start_d   = 1'b0;
    game_won_d      = game_won_q;
    game_over_d     = game_over_q;
    score_d         = score_q;
    misses_d        = misses_q;

    // Two flops of synchronisation, a third for edge detection, and the
    // detected edge itself is registered before the FSM consumes it.
    key_sync1_d = key;
    key_sync2_d = key_sync1_q;
    key_sync3_d = key_sync2_q;
    key_rise_d  = key_sync2_q & ~key_sync3_q;

    case (state_q)
      ST_START: begin
        target_write_d  = 1'b1;
        target_armed_d  = 1'b0;
        torpedo_armed_d = 1'b0;
        state_d         = ST_AIM;
      end

      ST_AIM: begin
        target_armed_d = target_armed_q | target_within_screen;
        // key_rise_q is a single-cycle pulse, so edges arriving in any other
        // state are simply dropped and a held key launches only once.
        if (key_rise_q) begin
          torpedo_write_d = 1'b1;
          torpedo_armed_d = 1'b0;
          timeout_cnt_d   = '0;
          state_d         = ST_FLIGHT;
        end else if (target_exit) begin
          state_d = ST_START;
        end
      end

      ST_FLIGHT: begin
        timeout_cnt_d   = timeout_cnt_q + 1'b1;
        target_armed_d  = target_armed_q | target_within_screen;
        torpedo_armed_d = torpedo_armed_q | torpedo_within_screen;
        if (collision) begin
          if (score_q != SCORE_MAX) begin
            score_d = score_q + 1'b1;
          end
          game_won_d    = 1'b1;
          timer_start_d = 1'b1;
          watchdog_d    = '0;
          state_d       = ST_END_WAIT_RISE;
        end else if (torpedo_exit || target_exit || timeout_hit) begin
          misses_d = misses_inc;
          if (misses_inc == MISS_LIMIT) begin
            game_over_d   = 1'b1;
            timer_start_d = 1'b1;
            watchdog_d    = '0;
            state_d       = ST_END_WAIT_RISE;
          end else begin
            state_d = ST_START;
          end
        end
      end

      ST_END_WAIT_RISE: begin
        // Watchdog: do not hang if the timer never acknowledges the start.
        if (end_of_game_timer_running || (watchdog_q == WATCHDOG_END)) begin
          state_d = ST_END_WAIT_FALL;
        end else begin
          watchdog_d = watchdog_q + 1'b1;
        end
      end

      ST_END_WAIT_FALL: begin
        if (!end_of_game_timer_running) begin
          game_won_d  = 1'b0;
          game_over_d = 1'b0;
          if (game_over_q) begin
            score_d  = '0;
            misses_d = '0;
          end
          state_d = ST_START;
        end
      end

      default: begin
        state_d = ST_START;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= ST_START;
      key_sync1_q     <= 1'b0;
      key_sync2_q     <= 1'b0;
      key_sync3_q     <= 1'b0;
      key_rise_q      <= 1'b0;
      target_armed_q  <= 1'b0;
      torpedo_armed_q <= 1'b0;
      timeout_cnt_q   <= '0;
      watchdog_q      <= '0;
      target_write_q  <= 1'b0;
      torpedo_write_q <= 1'b0;
      timer_start_q   <= 1'b0;
      game_won_q      <= 1'b0;
      game_over_q     <= 1'b0;
      score_q         <= '0;
      misses_q        <= '0;
    end else begin
      state_q         <= state_d;
      key_sync1_q     <= key_sync1_d;
      key_sync2_q     <= key_sync2_d;
      key_sync3_q     <= key_sync3_d;
      key_rise_q      <= key_rise_d;
      target_armed_q  <= target_armed_d;
      torpedo_armed_q <= torpedo_armed_d;
      timeout_cnt_q   <= timeout_cnt_d;
      watchdog_q      <= watchdog_d;
      target_write_q  <= target_write_d;
      torpedo_write_q <= torpedo_write_d;
      timer_start_q   <= timer_start_d;
      game_won_q      <= game_won_d;
      game_over_q     <= game_over_d;
      score_q         <= score_d;
      misses_q        <= misses_d;
    end
  end

  assign sprite_target_write     = target_write_q;
  assign sprite_torpedo_write    = torpedo_write_q;
  assign end_of_game_timer_start = timer_start_q;
  assign game_won                = game_won_q;
  assign game_over               = game_over_q;
  assign score                   = score_q;
  assign misses                  = misses_q;
  assign state                   = state_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_round_ctrl
//
// Drives directed rounds into game_round_ctrl and checks every output on every
// cycle against a round-level model (phase, counts, cycles since launch, key
// sample history), plus literal expectations at the key points of each round.
// -----------------------------------------------------------------------------
module tb_game_round_ctrl;

  localparam int SW   = 4;
  localparam int MW   = 2;
  localparam int MAXM = 3;
  localparam int TW   = 4;
  localparam int TIMEOUT_CYCLES = (1 << TW) - 1;
  localparam int SCORE_TOP      = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          key = 1'b0;
  logic          tws = 1'b1;
  logic          tps = 1'b0;
  logic          col = 1'b0;
  logic          run = 1'b0;
  logic          tw, tp, ts, won, over;
  logic [SW-1:0] score;
  logic [MW-1:0] misses;
  logic [2:0]    state;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  game_round_ctrl #(
    .SCORE_WIDTH  (SW),
    .MISS_WIDTH   (MW),
    .MAX_MISSES   (MAXM),
    .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .key                      (key),
    .target_within_screen     (tws),
    .torpedo_within_screen    (tps),
    .collision                (col),
    .end_of_game_timer_running(run),
    .sprite_target_write      (tw),
    .sprite_torpedo_write     (tp),
    .end_of_game_timer_start  (ts),
    .game_won                 (won),
    .game_over                (over),
    .score                    (score),
    .misses                   (misses),
    .state                    (state)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Round-level model: phase numbers are the documented state codes; the key is
  // kept as a history of raw samples and a launch is a 0->1 pair seen three
  // samples back.
  // ---------------------------------------------------------------------------
  int m_phase, m_score, m_misses, m_won, m_over, m_tw, m_tp, m_ts;
  int m_age, m_wait;
  bit m_tgt_seen, m_torp_seen;
  bit hist [5];

  task automatic model_step();
    bit launch, tgt_gone, torp_gone;
    if (!reset) begin
      m_phase = 0; m_score = 0; m_misses = 0; m_won = 0; m_over = 0;
      m_tw = 0; m_tp = 0; m_ts = 0; m_age = 0; m_wait = 0;
      m_tgt_seen = 0; m_torp_seen = 0;
      for (int i = 0; i < 5; i++) hist[i] = 1'b0;
    end else begin
      for (int i = 4; i > 0; i--) hist[i] = hist[i-1];
      hist[0]   = key;
      launch    = hist[3] && !hist[4];
      tgt_gone  = m_tgt_seen && !tws;
      torp_gone = m_torp_seen && !tps;
      m_tw = 0; m_tp = 0; m_ts = 0;
      case (m_phase)
        0: begin
          m_tw = 1; m_tgt_seen = 0; m_torp_seen = 0; m_phase = 1;
        end
        1: begin
          if (launch) begin
            m_tp = 1; m_age = 0; m_torp_seen = 0; m_phase = 2;
          end else if (tgt_gone) begin
            m_phase = 0;
          end
          m_tgt_seen = m_tgt_seen || tws;
        end
        2: begin
          m_age++;
          if (col) begin
            m_score = (m_score < SCORE_TOP) ? m_score + 1 : SCORE_TOP;
            m_won = 1; m_ts = 1; m_wait = 0; m_phase = 3;
          end else if (torp_gone || tgt_gone || m_age == TIMEOUT_CYCLES) begin
            m_misses++;
            if (m_misses == MAXM) begin
              m_over = 1; m_ts = 1; m_wait = 0; m_phase = 3;
            end else begin
              m_phase = 0;
            end
          end
          m_tgt_seen  = m_tgt_seen || tws;
          m_torp_seen = m_torp_seen || tps;
        end
        3: begin
          m_wait++;
          if (run || m_wait == 4) m_phase = 4;
        end
        4: begin
          if (!run) begin
            if (m_over != 0) begin
              m_score = 0; m_misses = 0;
            end
            m_won = 0; m_over = 0; m_phase = 0;
          end
        end
        default: m_phase = 0;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      chk("cyc_state",   int'(state),  m_phase);
      chk("cyc_tgt_wr",  int'(tw),     m_tw);
      chk("cyc_torp_wr", int'(tp),     m_tp);
      chk("cyc_tmr_st",  int'(ts),     m_ts);
      chk("cyc_won",     int'(won),    m_won);
      chk("cyc_over",    int'(over),   m_over);
      chk("cyc_score",   int'(score),  m_score);
      chk("cyc_misses",  int'(misses), m_misses);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_state(input int s, input int budget, input string name);
    int n = 0;
    while (int'(state) != s && n < budget) begin
      tick();
      n++;
    end
    chk(name, int'(state), s);
  endtask

  task automatic launch_torpedo(input string name);
    wait_state(1, 20, {name, "_aim"});
    key = 1'b1;
    wait_state(2, 10, {name, "_flight"});
    key = 1'b0;
  endtask

  initial begin
    int pulses;
    int pidx;

    // Reset state
    repeat (3) tick();
    check_en = 1'b1;
    chk("rst_state", int'(state), 0);
    chk("rst_pulses", int'({tw, tp, ts}), 0);
    chk("rst_flags", int'({won, over}), 0);
    chk("rst_counts", int'({score, misses}), 0);
    $display("txn reset: state=%0d score=%0d misses=%0d", state, score, misses);

    // Reset release: one target write, then AIM
    reset = 1'b1;
    tick();
    chk("t1_tgt_wr", int'(tw), 1);
    chk("t1_state", int'(state), 1);
    tick();
    chk("t1_tgt_wr_end", int'(tw), 0);
    $display("txn release: state=%0d", state);

    // Key held 10 cycles: exactly one launch, seen at the 4th sample point
    tps = 1'b1;
    key = 1'b1;
    pulses = 0;
    pidx = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (tp) begin
        pulses++;
        if (pidx == 0) pidx = i;
      end
    end
    key = 1'b0;
    chk("t2_pulses", pulses, 1);
    chk("t2_delay", pidx, 4);
    chk("t2_state", int'(state), 2);
    $display("txn launch: pulses=%0d at=%0d state=%0d", pulses, pidx, state);

    // Collision together with torpedo exit: the hit wins
    col = 1'b1;
    tps = 1'b0;
    tick();
    col = 1'b0;
    chk("t3_score", int'(score), 1);
    chk("t3_misses", int'(misses), 0);
    chk("t3_won", int'(won), 1);
    chk("t3_tmr_start", int'(ts), 1);
    chk("t3_state", int'(state), 3);
    tick();
    chk("t3_tmr_start_end", int'(ts), 0);
    run = 1'b1;
    repeat (5) tick();
    chk("t3_wait_fall", int'(state), 4);
    run = 1'b0;
    tick();
    chk("t3_restart", int'(state), 0);
    chk("t3_won_clr", int'(won), 0);
    chk("t3_score_kept", int'(score), 1);
    $display("txn hit: score=%0d misses=%0d state=%0d", score, misses, state);

    // Three armed torpedo exits end the game
    for (int i = 0; i < 3; i++) begin
      launch_torpedo("t4");
      tps = 1'b1;
      tick();
      tps = 1'b0;
      tick();
      chk("t4_misses", int'(misses), i + 1);
      if (i < 2) begin
        chk("t4_state", int'(state), 0);
      end else begin
        chk("t4_over", int'(over), 1);
        chk("t4_tmr_start", int'(ts), 1);
        chk("t4_state_end", int'(state), 3);
      end
      $display("txn miss %0d: misses=%0d over=%0d state=%0d", i + 1, misses, over, state);
    end
    run = 1'b1;
    tick();
    run = 1'b0;
    wait_state(0, 10, "t4_restart");
    chk("t4_score_clr", int'(score), 0);
    chk("t4_misses_clr", int'(misses), 0);
    chk("t4_over_clr", int'(over), 0);
    $display("txn game over cleared: score=%0d misses=%0d", score, misses);

    // Flight timeout: miss exactly 15 cycles after the launch pulse
    launch_torpedo("t5");
    chk("t5_launch", int'(tp), 1);
    repeat (TIMEOUT_CYCLES - 1) tick();
    chk("t5_no_miss_yet", int'(misses), 0);
    tick();
    chk("t5_miss", int'(misses), 1);
    chk("t5_state", int'(state), 0);
    $display("txn timeout: misses=%0d state=%0d", misses, state);

    // Timer never rises: watchdog leaves END_WAIT_RISE after 4 cycles
    launch_torpedo("t6");
    col = 1'b1;
    tick();
    col = 1'b0;
    chk("t6_state_rise", int'(state), 3);
    chk("t6_score", int'(score), 1);
    chk("t6_misses", int'(misses), 1);
    repeat (3) tick();
    chk("t6_still_rise", int'(state), 3);
    tick();
    chk("t6_to_fall", int'(state), 4);
    tick();
    chk("t6_restart", int'(state), 0);
    chk("t6_won_clr", int'(won), 0);
    $display("txn watchdog: state=%0d score=%0d", state, score);

    // Reset in the middle of a flight
    launch_torpedo("t7");
    reset = 1'b0;
    tick();
    chk("t7_state", int'(state), 0);
    chk("t7_pulses", int'({tw, tp, ts}), 0);
    chk("t7_flags", int'({won, over}), 0);
    chk("t7_counts", int'({score, misses}), 0);
    reset = 1'b1;
    $display("txn mid-flight reset: state=%0d score=%0d", state, score);

    // Armed target leaving the screen while aiming: new target, no miss
    wait_state(1, 10, "t8_aim");
    tick();
    tws = 1'b0;
    tick();
    chk("t8_state", int'(state), 0);
    chk("t8_misses", int'(misses), 0);
    tws = 1'b1;
    $display("txn target exit: state=%0d misses=%0d", state, misses);

    // Sixteen hits: the score saturates at all-ones
    for (int k = 0; k < 16; k++) begin
      launch_torpedo("t9");
      col = 1'b1;
      tick();
      col = 1'b0;
      run = 1'b1;
      tick();
      run = 1'b0;
      wait_state(0, 10, "t9_restart");
    end
    chk("t9_score_sat", int'(score), SCORE_TOP);
    $display("txn saturation: score=%0d", score);

    tick();
    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    bad++;
    $display("FAIL global_timeout: got running expected finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
